// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch sequencing logic.
//   ADDR_W_DEF / STEP_DEF : default program-address width and sequential step.
//   op_e                  : one-hot-free op code chosen each cycle by the
//                           command priority encoder.
//   sel_op()              : the priority encoder itself
//                           (stall > ret > call > jmp > br > inc).
package cpu_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int STEP_DEF   = 4;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_INC  = 3'd1,
    OP_JMP  = 3'd2,
    OP_BR   = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5
  } op_e;

  // Stall folds into OP_HOLD so every downstream mux and the stack see
  // "no operation" without separate gating.
  function automatic op_e sel_op(input logic stall,
                                 input logic ret,
                                 input logic call,
                                 input logic jmp,
                                 input logic br,
                                 input logic inc);
    op_e op;
    if (stall)     op = OP_HOLD;
    else if (ret)  op = OP_RET;
    else if (call) op = OP_CALL;
    else if (jmp)  op = OP_JMP;
    else if (br)   op = OP_BR;
    else if (inc)  op = OP_INC;
    else           op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/return_stack.sv
// Registered LIFO used as the hardware return-address stack.
//   clk, rst       : clock, synchronous active-low reset (clears sp only).
//   push/push_data : write push_data on top; ignored when full.
//   pop            : discard top entry; ignored when empty.
//   top_data       : current top entry (don't-care when empty).
//   sp             : number of valid entries, 0..DEPTH.
//   full/empty     : sp==DEPTH / sp==0.
// Refusal and error flagging on full/empty are decided by the caller; the
// internal guards only keep the pointer in range.
module return_stack #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int SP_W  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [W-1:0]    push_data,
  output logic [W-1:0]    top_data,
  output logic [SP_W-1:0] sp,
  output logic            full,
  output logic            empty
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]    mem_q [2**IDX_W];
  logic [W-1:0]    mem_d [2**IDX_W];
  logic [SP_W-1:0] sp_q, sp_d;
  logic [IDX_W-1:0] wr_idx, top_idx;

  assign full    = (sp_q == SP_W'(DEPTH));
  assign empty   = (sp_q == '0);
  assign wr_idx  = IDX_W'(sp_q);
  assign top_idx = IDX_W'(sp_q - SP_W'(1));
  assign top_data = mem_q[top_idx];
  assign sp      = sp_q;

  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    if (push && !full) begin
      mem_d[wr_idx] = push_data;
      sp_d          = sp_q + SP_W'(1);
    end else if (pop && !empty) begin
      sp_d = sp_q - SP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) sp_q <= '0;
    else      sp_q <= sp_d;
  end

  // Contents are don't-care after reset, so storage carries no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter for the fetch stage with a hardware return-address stack.
//   clk, rst                 : clock, synchronous active-low reset.
//   stall                    : freeze all state; overrides every command.
//   inc/jmp/br/call/ret      : commands, priority ret > call > jmp > br > inc.
//   tgt                      : absolute target for jmp/call.
//   off                      : two's-complement branch offset.
//   pc                       : registered fetch address.
//   sp                       : valid return-stack entries.
//   ovf/unf                  : sticky call-when-full / ret-when-empty flags.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                STEP        = STEP_DEF,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               stall,
  input  logic                               inc,
  input  logic                               jmp,
  input  logic                               br,
  input  logic                               call,
  input  logic                               ret,
  input  logic [ADDR_W-1:0]                  tgt,
  input  logic [ADDR_W-1:0]                  off,
  output logic [ADDR_W-1:0]                  pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
  output logic                               ovf,
  output logic                               unf
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  op_e              op;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_seq;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push, pop;
  logic [ADDR_W-1:0] top_data;
  logic             full, empty;

  assign op     = sel_op(stall, ret, call, jmp, br, inc);
  assign pc_seq = pc_q + ADDR_W'(STEP);

  // A refused call or ret leaves pc where it is and only raises its flag.
  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    pop   = 1'b0;
    case (op)
      OP_INC: pc_d = pc_seq;
      OP_JMP: pc_d = tgt;
      OP_BR:  pc_d = pc_q + off;
      OP_CALL: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          push = 1'b1;
          pc_d = tgt;
        end
      end
      OP_RET: begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          pop  = 1'b1;
          pc_d = top_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q  <= RESET_ADDR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  return_stack #(
    .W     (ADDR_W),
    .DEPTH (STACK_DEPTH),
    .SP_W  (SP_W)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_seq),
    .top_data  (top_data),
    .sp        (sp),
    .full      (full),
    .empty     (empty)
  );

  assign pc  = pc_q;
  assign ovf = ovf_q;
  assign unf = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer at ADDR_W=5, STEP=4, STACK_DEPTH=4, RESET_ADDR=0.
// Directed table of hand-derived vectors, then randomized commands checked
// against a queue-based reference model of the program counter and stack.
module tb_pc_sequencer;

  localparam int AW    = 5;
  localparam int STEP  = 4;
  localparam int DEPTH = 4;
  localparam int MOD   = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, stall, inc, jmp, br, call, ret;
  logic [AW-1:0] tgt, off;
  logic [AW-1:0] pc;
  logic [2:0]    sp;
  logic          ovf, unf;

  int errors = 0;
  int checks = 0;

  pc_sequencer #(
    .ADDR_W      (AW),
    .STEP        (STEP),
    .STACK_DEPTH (DEPTH),
    .RESET_ADDR  ('0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .inc   (inc),
    .jmp   (jmp),
    .br    (br),
    .call  (call),
    .ret   (ret),
    .tgt   (tgt),
    .off   (off),
    .pc    (pc),
    .sp    (sp),
    .ovf   (ovf),
    .unf   (unf)
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    logic          rst, stall, inc, jmp, br, call, ret;
    logic [AW-1:0] tgt, off;
    logic [AW-1:0] pc;
    logic [2:0]    sp;
    logic          ovf, unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, s, i, j, b, c, t_ret,
                              input int t, o, p, spv,
                              input logic ov, un);
    vec_t v;
    v.rst = r; v.stall = s; v.inc = i; v.jmp = j; v.br = b;
    v.call = c; v.ret = t_ret;
    v.tgt = AW'(t); v.off = AW'(o); v.pc = AW'(p); v.sp = 3'(spv);
    v.ovf = ov; v.unf = un;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, s, i, j, b, c, t_ret,
                       input logic [AW-1:0] t, o);
    rst = r; stall = s; inc = i; jmp = j; br = b; call = c; ret = t_ret;
    tgt = t; off = o;
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  int m_pc;
  int m_stk[$];
  bit m_ovf, m_unf;

  task automatic model_step(input logic r, s, i, j, b, c, t_ret,
                            input int t, o);
    if (!r) begin
      m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else if (!s) begin
      if (t_ret) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else                  m_unf = 1;
      end else if (c) begin
        if (m_stk.size() < DEPTH) begin
          m_stk.push_back((m_pc + STEP) % MOD);
          m_pc = t;
        end else m_ovf = 1;
      end else if (j) m_pc = t;
      else if (b)     m_pc = (m_pc + o) % MOD;
      else if (i)     m_pc = (m_pc + STEP) % MOD;
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, '0, '0);

    //            rst st in jm br ca re tgt off   pc sp ov un
    // reset for two cycles
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0,  0,   0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0,  0,   0, 0, 0, 0));
    // sequential increment with wrap at 32
    for (int k = 1; k <= 10; k++)
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, (4 * k) % 32, 0, 0, 0));
    // jump / branch / priority of br over inc
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 20,  0,  20, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0,  0, 28,  16, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 0, 0,  0, 28,  12, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0,  0,  0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  0,   0, 0, 0, 0));
    // call/ret nesting
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 10,  0,  10, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 20,  0,  20, 2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1,  0,  0,  14, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1,  0,  0,   4, 0, 0, 0));
    // fill stack (pushes 8,5,6,7), then overflow
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0,  1,  0,   1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0,  2,  0,   2, 2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0,  3,  0,   3, 3, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0,  7,  0,   7, 4, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0,  9,  0,   7, 4, 1, 0));
    // stall overrides ret+call; release: ret wins over call
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 1,  9,  0,   7, 4, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1,  9,  0,   7, 3, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1,  0,  0,   6, 2, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1,  0,  0,   5, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1,  0,  0,   8, 0, 1, 0));
    // underflow, flags sticky
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1,  0,  0,   8, 0, 1, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,  0,  0,  12, 0, 1, 1));
    vecs.push_back(mk(1, 0, 1, 1, 1, 0, 0,  3,  9,   3, 0, 1, 1));
    // rebuild sp=3 (pushes 7,5,6), then reset together with call
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0,  1,  0,   1, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0,  2,  0,   2, 2, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0,  3,  0,   3, 3, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,  9,  0,   0, 0, 0, 0));
    // fresh after reset: ret underflows, stack really empty
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1,  0,  0,   0, 0, 0, 1));
    // reset beats stall
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 17,  0,  17, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,  0,  0,   0, 0, 0, 0));
    // backward branch wraps, increment wraps
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0,  0, 31,  31, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,  0,  0,   3, 0, 0, 0));

    foreach (vecs[n]) begin
      drive(vecs[n].rst, vecs[n].stall, vecs[n].inc, vecs[n].jmp, vecs[n].br,
            vecs[n].call, vecs[n].ret, vecs[n].tgt, vecs[n].off);
      tick();
      check($sformatf("vec%0d_pc", n),  int'(pc),  int'(vecs[n].pc));
      check($sformatf("vec%0d_sp", n),  int'(sp),  int'(vecs[n].sp));
      check($sformatf("vec%0d_ovf", n), int'(ovf), int'(vecs[n].ovf));
      check($sformatf("vec%0d_unf", n), int'(unf), int'(vecs[n].unf));
    end

    // Random phase: start from reset, then mixed commands.
    model_step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, '0, '0);
    tick();
    for (int n = 0; n < 400; n++) begin
      logic r, s, i, j, b, c, t_ret;
      int t, o;
      r     = ($urandom_range(0, 49) != 0);
      s     = ($urandom_range(0, 7) == 0);
      i     = ($urandom_range(0, 1) == 1);
      j     = ($urandom_range(0, 5) == 0);
      b     = ($urandom_range(0, 4) == 0);
      c     = ($urandom_range(0, 3) == 0);
      t_ret = ($urandom_range(0, 3) == 0);
      t     = $urandom_range(0, MOD - 1);
      o     = $urandom_range(0, MOD - 1);
      drive(r, s, i, j, b, c, t_ret, AW'(t), AW'(o));
      model_step(r, s, i, j, b, c, t_ret, t, o);
      tick();
      check($sformatf("rnd%0d_pc", n),  int'(pc),  m_pc);
      check($sformatf("rnd%0d_sp", n),  int'(sp),  m_stk.size());
      check($sformatf("rnd%0d_ovf", n), int'(ovf), int'(m_ovf));
      check($sformatf("rnd%0d_unf", n), int'(unf), int'(m_unf));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
